// File: rtl/seven_segment_scanner_pkg.sv
// Shared definitions for the seven-segment scan controller.
//
// Contents:
//   scan_state_e  - scanner state encoding (IDLE / BLANK / DRIVE)
//   SEG_OFF       - all segments dark
//   SEG_DP        - decimal-point segment bit
//   HEX_SEG       - hex nibble to active-high {a,b,c,d,e,f,g,dp} pattern
//   segPattern()  - full per-digit pattern including dp and blanking
package seven_segment_scanner_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_DRIVE = 2'd2
  } scan_state_e;

  localparam logic [7:0] SEG_OFF = 8'h00;
  localparam logic [7:0] SEG_DP  = 8'h01;

  localparam logic [7:0] HEX_SEG [16] = '{
    8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
    8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E
  };

  // Blank wins over the decimal point: a blanked digit is fully dark.
  function automatic logic [7:0] segPattern(input logic [3:0] nibble,
                                            input logic       dp,
                                            input logic       blank);
    logic [7:0] pat;
    pat = HEX_SEG[nibble];
    if (dp) begin
      pat = pat | SEG_DP;
    end
    if (blank) begin
      pat = SEG_OFF;
    end
    return pat;
  endfunction

endpackage

// File: rtl/seven_segment_scanner_slot_timer.sv
// Slot timer for the seven-segment scanner.
//
// Counts the cycles of one digit slot (0..PRESCALE-1) and reports where the
// slot is heading so the parent can register its outputs on the same edge.
//
// Ports:
//   clk_i           system clock
//   rst_n_i         asynchronous active-low reset
//   run_i           1 = count, 0 = hold counter at 0
//   slot_end_o      current cycle is the last cycle of the slot
//   next_blank_o    next cycle lies in the blanking gap of its slot
//   next_slot_end_o next cycle is the last cycle of its slot
module scan_slot_timer
  import seven_segment_scanner_pkg::*;
#(
  parameter int PRESCALE     = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic run_i,
  output logic slot_end_o,
  output logic next_blank_o,
  output logic next_slot_end_o
);

  localparam int CNT_W = $clog2(PRESCALE);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign slot_end_o = (cnt_q == CNT_W'(PRESCALE - 1));

  // Stopping the timer always returns it to the start of a slot, so a
  // restart begins with a full blanking gap.
  always_comb begin
    cnt_d = '0;
    if (run_i && !slot_end_o) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign next_blank_o    = (cnt_d < CNT_W'(BLANK_CYCLES));
  assign next_slot_end_o = (cnt_d == CNT_W'(PRESCALE - 1));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/seven_segment_scanner.sv
// Time-multiplexed scan controller for common-anode seven-segment digits.
//
// A display word is accepted through a valid/ready handshake into a pending
// register and copied to the live display only at a frame boundary (or right
// away while idle), so one frame never mixes old and new digits.
//
// Ports:
//   clk_i          system clock
//   rst_n_i        asynchronous active-low reset
//   enable_i       1 = scan, 0 = display dark
//   load_valid_i   new display word offered
//   load_ready_o   scanner can accept a word
//   load_data_i    hex nibble per digit, digit 0 in bits [3:0]
//   load_dp_i      decimal point per digit
//   load_blank_i   1 = digit fully dark
//   seg_o          {a,b,c,d,e,f,g,dp}, active-high, registered
//   an_o           anode select, active-low, registered
//   frame_done_o   pulse on the last cycle of the last digit slot
module seven_segment_scanner
  import seven_segment_scanner_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int PRESCALE     = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    enable_i,
  input  logic                    load_valid_i,
  output logic                    load_ready_o,
  input  logic [4*NUM_DIGITS-1:0] load_data_i,
  input  logic [NUM_DIGITS-1:0]   load_dp_i,
  input  logic [NUM_DIGITS-1:0]   load_blank_i,
  output logic [7:0]              seg_o,
  output logic [NUM_DIGITS-1:0]   an_o,
  output logic                    frame_done_o
);

  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DATA_W = 4 * NUM_DIGITS;

  scan_state_e               state_q, state_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [DATA_W-1:0]         dispData_q, dispData_d;
  logic [NUM_DIGITS-1:0]     dispDp_q, dispDp_d;
  logic [NUM_DIGITS-1:0]     dispBlank_q, dispBlank_d;
  logic [DATA_W-1:0]         pendData_q, pendData_d;
  logic [NUM_DIGITS-1:0]     pendDp_q, pendDp_d;
  logic [NUM_DIGITS-1:0]     pendBlank_q, pendBlank_d;
  logic                      ready_q, ready_d;
  logic [7:0]                seg_q, seg_d;
  logic [NUM_DIGITS-1:0]     an_q, an_d;
  logic                      frameDone_q, frameDone_d;

  logic                      slotEnd;
  logic                      nextBlank;
  logic                      nextSlotEnd;
  logic                      transfer;
  logic                      commit;

  scan_slot_timer #(
    .PRESCALE     (PRESCALE),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_slot_timer (
    .clk_i           (clk_i),
    .rst_n_i         (rst_n_i),
    .run_i           (enable_i && (state_q != ST_IDLE)),
    .slot_end_o      (slotEnd),
    .next_blank_o    (nextBlank),
    .next_slot_end_o (nextSlotEnd)
  );

  // Next-state logic. Outputs are computed from the next state and the
  // next display contents so that they land in their registers on the same
  // edge as the state they describe. ready_q low doubles as "pending word
  // held"; commit only looks at words accepted on earlier cycles, so a word
  // accepted during frame_done waits for the following frame boundary.
  always_comb begin
    transfer = load_valid_i && ready_q;
    commit   = !ready_q && ((state_q == ST_IDLE) || frameDone_q);

    pendData_d  = pendData_q;
    pendDp_d    = pendDp_q;
    pendBlank_d = pendBlank_q;
    if (transfer) begin
      pendData_d  = load_data_i;
      pendDp_d    = load_dp_i;
      pendBlank_d = load_blank_i;
    end

    dispData_d  = dispData_q;
    dispDp_d    = dispDp_q;
    dispBlank_d = dispBlank_q;
    if (commit) begin
      dispData_d  = pendData_q;
      dispDp_d    = pendDp_q;
      dispBlank_d = pendBlank_q;
    end

    ready_d = ready_q;
    if (commit) begin
      ready_d = 1'b1;
    end else if (transfer) begin
      ready_d = 1'b0;
    end

    idx_d = idx_q;
    if (!enable_i || (state_q == ST_IDLE)) begin
      idx_d = '0;
    end else if (slotEnd) begin
      idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end

    if (!enable_i) begin
      state_d = ST_IDLE;
    end else if (nextBlank) begin
      state_d = ST_BLANK;
    end else begin
      state_d = ST_DRIVE;
    end

    frameDone_d = (state_d != ST_IDLE) && nextSlotEnd &&
                  (idx_d == IDX_W'(NUM_DIGITS - 1));

    seg_d = SEG_OFF;
    an_d  = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_d == IDX_W'(i)) begin
        if (state_d != ST_IDLE) begin
          seg_d = segPattern(dispData_d[4*i +: 4], dispDp_d[i], dispBlank_d[i]);
        end
        if (state_d == ST_DRIVE) begin
          an_d[i] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      dispData_q  <= '0;
      dispDp_q    <= '0;
      dispBlank_q <= '0;
      pendData_q  <= '0;
      pendDp_q    <= '0;
      pendBlank_q <= '0;
      ready_q     <= 1'b1;
      seg_q       <= SEG_OFF;
      an_q        <= '1;
      frameDone_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      dispData_q  <= dispData_d;
      dispDp_q    <= dispDp_d;
      dispBlank_q <= dispBlank_d;
      pendData_q  <= pendData_d;
      pendDp_q    <= pendDp_d;
      pendBlank_q <= pendBlank_d;
      ready_q     <= ready_d;
      seg_q       <= seg_d;
      an_q        <= an_d;
      frameDone_q <= frameDone_d;
    end
  end

  assign load_ready_o = ready_q;
  assign seg_o        = seg_q;
  assign an_o         = an_q;
  assign frame_done_o = frameDone_q;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Self-checking bench for seven_segment_scanner (4 digits, 8-cycle slots,
// 2-cycle blanking gap). The reference model tracks the scan as a single
// frame position plus display/pending words.
module tb_seven_segment_scanner;

  localparam int N = 4;
  localparam int P = 8;
  localparam int B = 2;
  localparam int FRAME = N * P;

  localparam logic [7:0] SEG_TAB [16] = '{
    8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
    8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E
  };

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        load_valid;
  logic        load_ready;
  logic [15:0] load_data;
  logic [3:0]  load_dp;
  logic [3:0]  load_blank;
  logic [7:0]  seg;
  logic [3:0]  an;
  logic        frame_done;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic        mScan;
  int          mPos;
  logic [15:0] mDisp;
  logic [3:0]  mDispDp;
  logic [3:0]  mDispBl;
  logic [15:0] mPend;
  logic [3:0]  mPendDp;
  logic [3:0]  mPendBl;
  logic        mHasPend;
  logic [3:0]  mAn;
  logic [7:0]  mSeg;
  logic        mFd;
  logic        mReady;

  always #5 clk = ~clk;

  seven_segment_scanner #(
    .NUM_DIGITS   (N),
    .PRESCALE     (P),
    .BLANK_CYCLES (B)
  ) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .enable_i     (enable),
    .load_valid_i (load_valid),
    .load_ready_o (load_ready),
    .load_data_i  (load_data),
    .load_dp_i    (load_dp),
    .load_blank_i (load_blank),
    .seg_o        (seg),
    .an_o         (an),
    .frame_done_o (frame_done)
  );

  function automatic logic [7:0] refSeg(input int d);
    logic [3:0] nib;
    nib = mDisp[4*d +: 4];
    if (mDispBl[d]) return 8'h00;
    return SEG_TAB[nib] | (mDispDp[d] ? 8'h01 : 8'h00);
  endfunction

  task automatic computeExpected();
    int d;
    int ph;
    logic [3:0] oneHot;
    mReady = !mHasPend;
    if (!mScan) begin
      mAn  = 4'hF;
      mSeg = 8'h00;
      mFd  = 1'b0;
    end else begin
      d      = mPos / P;
      ph     = mPos % P;
      oneHot = 4'b0001 << d;
      mSeg   = refSeg(d);
      mAn    = (ph < B) ? 4'hF : ~oneHot;
      mFd    = (mPos == FRAME - 1);
    end
  endtask

  task automatic modelReset();
    mScan    = 1'b0;
    mPos     = 0;
    mDisp    = '0;
    mDispDp  = '0;
    mDispBl  = '0;
    mPend    = '0;
    mPendDp  = '0;
    mPendBl  = '0;
    mHasPend = 1'b0;
    computeExpected();
  endtask

  // Drive one cycle of inputs, advance the model across the edge, and leave
  // the bench 1 time unit after the edge where outputs are sampled.
  task automatic step(input logic en, input logic v, input logic [15:0] d,
                      input logic [3:0] dp, input logic [3:0] bl);
    logic fdNow;
    logic xfer;
    logic com;
    enable     = en;
    load_valid = v;
    load_data  = d;
    load_dp    = dp;
    load_blank = bl;
    @(posedge clk);
    fdNow = mScan && (mPos == FRAME - 1);
    xfer  = v && !mHasPend;
    com   = mHasPend && (!mScan || fdNow);
    if (com) begin
      mDisp    = mPend;
      mDispDp  = mPendDp;
      mDispBl  = mPendBl;
      mHasPend = 1'b0;
    end
    if (xfer) begin
      mPend    = d;
      mPendDp  = dp;
      mPendBl  = bl;
      mHasPend = 1'b1;
    end
    if (!en) begin
      mScan = 1'b0;
      mPos  = 0;
    end else if (!mScan) begin
      mScan = 1'b1;
      mPos  = 0;
    end else begin
      mPos = (mPos + 1) % FRAME;
    end
    computeExpected();
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(1'b0, 1'b0, 16'h0, 4'h0, 4'h0);
    step(1'b0, 1'b0, 16'h0, 4'h0, 4'h0);
    total++;
    if ({an, seg, load_ready, frame_done} !== {4'hF, 8'h00, 1'b1, 1'b0}) begin
      bad++;
      $display("[TB] FAIL reset_hold an=%b seg=%h rdy=%b fd=%b expected an=1111 seg=00 rdy=1 fd=0",
               an, seg, load_ready, frame_done);
    end
    #4 rst_n = 1'b1;
    modelReset();
    step(1'b0, 1'b1, 16'h9999, 4'hF, 4'h0);
    for (int k = 0; k < 12; k++) begin
      step(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
    end
    #3 rst_n = 1'b0;
    #1;
    total++;
    if ({an, seg, load_ready, frame_done} !== {4'hF, 8'h00, 1'b1, 1'b0}) begin
      bad++;
      $display("[TB] FAIL reset_async an=%b seg=%h rdy=%b fd=%b expected an=1111 seg=00 rdy=1 fd=0",
               an, seg, load_ready, frame_done);
    end
    rst_n = 1'b1;
    modelReset();
  endtask

  task automatic test_basic_frame();
    logic [7:0] expSeg [4];
    logic [3:0] oneHot;
    logic [3:0] expAn;
    expSeg[0] = 8'h66;
    expSeg[1] = 8'hF2;
    expSeg[2] = 8'hDA;
    expSeg[3] = 8'h60;
    step(1'b0, 1'b1, 16'h1234, 4'h0, 4'h0);
    total++;
    if (load_ready !== 1'b0) begin
      bad++;
      $display("[TB] FAIL idle_accept_ready got=%b expected=0", load_ready);
    end
    step(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
    for (int c = 0; c < FRAME; c++) begin
      oneHot = 4'b0001 << (c / P);
      expAn  = ((c % P) < B) ? 4'hF : ~oneHot;
      total++;
      if ({an, seg, frame_done, load_ready} !== {expAn, expSeg[c / P], (c == FRAME - 1), 1'b1} ||
          {an, seg, load_ready, frame_done} !== {mAn, mSeg, mReady, mFd}) begin
        bad++;
        $display("[TB] FAIL basic_frame cycle=%0d an=%b seg=%h fd=%b rdy=%b expected an=%b seg=%h fd=%b rdy=1",
                 c, an, seg, frame_done, load_ready, expAn, expSeg[c / P], (c == FRAME - 1));
      end
      step(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
    end
  endtask

  task automatic test_midframe_load();
    for (int k = 0; k < 10; k++) begin
      step(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
    end
    step(1'b1, 1'b1, 16'hABCD, 4'h0, 4'h0);
    total++;
    if (load_ready !== 1'b0 || seg !== mSeg || seg !== 8'hF2) begin
      bad++;
      $display("[TB] FAIL midframe_hold rdy=%b seg=%h expected rdy=0 seg=f2", load_ready, seg);
    end
    for (int k = 0; k < FRAME + 2; k++) begin
      step(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
      total++;
      if ({an, seg, load_ready, frame_done} !== {mAn, mSeg, mReady, mFd}) begin
        bad++;
        $display("[TB] FAIL midframe_model pos=%0d an=%b seg=%h rdy=%b fd=%b expected an=%b seg=%h rdy=%b fd=%b",
                 mPos, an, seg, load_ready, frame_done, mAn, mSeg, mReady, mFd);
      end
      if (mFd) break;
    end
    step(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
    total++;
    if (seg !== 8'h7A || load_ready !== 1'b1 || mPos != 0) begin
      bad++;
      $display("[TB] FAIL midframe_commit seg=%h rdy=%b pos=%0d expected seg=7a rdy=1 pos=0",
               seg, load_ready, mPos);
    end
  endtask

  task automatic test_dp_blank();
    logic [7:0] expSeg [4];
    logic [3:0] oneHot;
    expSeg[0] = 8'hBE;
    expSeg[1] = 8'hB7;
    expSeg[2] = 8'hFC;
    expSeg[3] = 8'h00;
    step(1'b1, 1'b1, 16'h0056, 4'b0010, 4'b1000);
    for (int k = 0; k < FRAME + 2; k++) begin
      step(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
      if (mFd) break;
    end
    step(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
    for (int c = 0; c < FRAME; c++) begin
      total++;
      if ({an, seg, load_ready, frame_done} !== {mAn, mSeg, mReady, mFd}) begin
        bad++;
        $display("[TB] FAIL dpblank_model pos=%0d an=%b seg=%h rdy=%b fd=%b expected an=%b seg=%h rdy=%b fd=%b",
                 mPos, an, seg, load_ready, frame_done, mAn, mSeg, mReady, mFd);
      end
      if ((c % P) == 4) begin
        oneHot = 4'b0001 << (c / P);
        total++;
        if (seg !== expSeg[c / P] || an !== ~oneHot) begin
          bad++;
          $display("[TB] FAIL dpblank_digit%0d seg=%h an=%b expected seg=%h an=%b",
                   c / P, seg, an, expSeg[c / P], ~oneHot);
        end
      end
      step(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < FRAME + 2; k++) begin
      if (mFd) break;
      step(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
    end
    // word offered on the frame_done cycle itself
    step(1'b1, 1'b1, 16'h8888, 4'h0, 4'h0);
    total++;
    if (load_ready !== 1'b0 || seg !== 8'hBE || mPos != 0) begin
      bad++;
      $display("[TB] FAIL b2b_deferred rdy=%b seg=%h expected rdy=0 seg=be", load_ready, seg);
    end
    for (int k = 0; k < FRAME + 2; k++) begin
      step(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
      total++;
      if ({an, seg, load_ready, frame_done} !== {mAn, mSeg, mReady, mFd}) begin
        bad++;
        $display("[TB] FAIL b2b_model pos=%0d an=%b seg=%h rdy=%b fd=%b expected an=%b seg=%h rdy=%b fd=%b",
                 mPos, an, seg, load_ready, frame_done, mAn, mSeg, mReady, mFd);
      end
      if (mFd) break;
    end
    step(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
    total++;
    if (seg !== 8'hFE || load_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL b2b_commit seg=%h rdy=%b expected seg=fe rdy=1", seg, load_ready);
    end
  endtask

  task automatic test_enable_drop();
    for (int k = 0; k < FRAME + 2; k++) begin
      if (mPos == 2 * P + 3) break;
      step(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
    end
    total++;
    if (an !== 4'b1011) begin
      bad++;
      $display("[TB] FAIL drop_pre an=%b expected an=1011", an);
    end
    step(1'b0, 1'b0, 16'h0, 4'h0, 4'h0);
    total++;
    if ({an, seg, frame_done} !== {4'hF, 8'h00, 1'b0}) begin
      bad++;
      $display("[TB] FAIL drop_dark an=%b seg=%h fd=%b expected an=1111 seg=00 fd=0",
               an, seg, frame_done);
    end
    step(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
    total++;
    if ({an, seg} !== {4'hF, 8'hFE}) begin
      bad++;
      $display("[TB] FAIL restart_blank an=%b seg=%h expected an=1111 seg=fe", an, seg);
    end
    step(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
    step(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
    total++;
    if ({an, seg} !== {4'b1110, 8'hFE} || {an, seg} !== {mAn, mSeg}) begin
      bad++;
      $display("[TB] FAIL restart_drive an=%b seg=%h expected an=1110 seg=fe", an, seg);
    end
  endtask

  task automatic test_reset_pending();
    step(1'b1, 1'b1, 16'h4321, 4'h0, 4'h0);
    step(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
    step(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
    total++;
    if (load_ready !== 1'b0 || mFd) begin
      bad++;
      $display("[TB] FAIL rstpend_pending rdy=%b expected rdy=0", load_ready);
    end
    #3 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    modelReset();
    step(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
    total++;
    if ({seg, an, load_ready} !== {8'hFC, 4'hF, 1'b1}) begin
      bad++;
      $display("[TB] FAIL rstpend_discard seg=%h an=%b rdy=%b expected seg=fc an=1111 rdy=1",
               seg, an, load_ready);
    end
  endtask

  task automatic test_random();
    logic        en;
    logic        v;
    logic [15:0] d;
    logic [3:0]  dp;
    logic [3:0]  bl;
    for (int k = 0; k < 800; k++) begin
      en = ($urandom_range(0, 19) != 0);
      v  = ($urandom_range(0, 3) == 0);
      d  = 16'($urandom);
      dp = 4'($urandom);
      bl = 4'($urandom) & 4'($urandom);
      step(en, v, d, dp, bl);
      total++;
      if ({an, seg, load_ready, frame_done} !== {mAn, mSeg, mReady, mFd}) begin
        bad++;
        $display("[TB] FAIL random k=%0d an=%b seg=%h rdy=%b fd=%b expected an=%b seg=%h rdy=%b fd=%b",
                 k, an, seg, load_ready, frame_done, mAn, mSeg, mReady, mFd);
      end
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    enable     = 1'b0;
    load_valid = 1'b0;
    load_data  = '0;
    load_dp    = '0;
    load_blank = '0;
    modelReset();
    test_reset();
    test_basic_frame();
    test_midframe_load();
    test_dp_blank();
    test_back_to_back();
    test_enable_drop();
    test_reset_pending();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seven_segment_scanner.md
Name: seven_segment_scanner

Overview:
Time-multiplexed scan controller for a bank of common-anode seven-segment digits. It holds a display word loaded through a valid/ready handshake and cycles through the digits, one at a time. For each digit it drives that digit's segment pattern and anode, with a ghost-suppression blanking gap before each digit. New data is committed only at frame boundaries, so a frame never shows a mix of old and new digits (no tearing). It sits between the link/status logic and the board display pins.

Parameters:
NUM_DIGITS, 4, digits scanned (1..8); digit 0 = rightmost = load_data[3:0]
PRESCALE, 50000, clock cycles per digit slot (>= 2)
BLANK_CYCLES, 16, cycles at start of each slot with all anodes off (1..PRESCALE-1)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
enable  input  1  1 = scan, 0 = display dark
load_valid  input  1  new display word offered
load_ready  output  1  scanner can accept a word
load_data  input  4*NUM_DIGITS  hex nibble per digit
load_dp  input  NUM_DIGITS  decimal point per digit
load_blank  input  NUM_DIGITS  1 = digit fully dark
seg  output  8  {a,b,c,d,e,f,g,dp}, active-high, registered
an  output  NUM_DIGITS  anode select, active-low, registered
frame_done  output  1  one-cycle pulse at last cycle of last digit slot

Behaviour:
- Reset (async assert, sync release): an all 1, seg 8'h00, load_ready 1, frame_done 0. Display and pending registers 0; digit_idx 0; slot counter 0; state IDLE.
- States: IDLE, BLANK, DRIVE.
- IDLE: an all 1, seg 0. When enable=1, next state is BLANK with digit_idx 0 and counter 0.
- Slot counter runs 0..PRESCALE-1.
- BLANK covers counter 0..BLANK_CYCLES-1: an all 1, seg = pattern of digit_idx.
- DRIVE covers counter BLANK_CYCLES..PRESCALE-1: an[digit_idx]=0, others 1, seg = pattern of digit_idx.
- At counter PRESCALE-1: counter goes to 0, digit_idx increments and wraps NUM_DIGITS-1 -> 0, state goes to BLANK.
- frame_done=1 during the cycle where counter=PRESCALE-1 and digit_idx=NUM_DIGITS-1.
- Frame length = NUM_DIGITS*PRESCALE cycles.
- Outputs are registered: state, counter and outputs all update on the same edge, with no extra pipeline stage.
- Pattern: table[nibble], OR'd with 8'h01 when dp bit is set. Forced to 8'h00 when the blank bit is set (blank overrides dp).
- Pattern table (active-high hex): 0 FC, 1 60, 2 DA, 3 F2, 4 66, 5 B6, 6 BE, 7 E0, 8 FE, 9 F6, A EE, B 3E, C 9C, D 7A, E 9E, F 8E.
- Handshake: a transfer occurs on a cycle with load_valid & load_ready. It latches data, dp and blank into the pending register; load_ready goes 0 the next cycle.
- Commit, while scanning: pending -> display on the frame_done cycle edge; load_ready returns to 1 the next cycle.
- Commit, in IDLE: pending -> display on the cycle after acceptance.
- A transfer coinciding with frame_done is held pending until the next frame boundary.
- enable falling in any state: next cycle IDLE with outputs dark and counter/digit_idx cleared. A pending word still commits via the IDLE rule.
- Reset mid-frame: pending word is discarded.
- load_data width is exactly 4*NUM_DIGITS; no truncation or extension.

Decomposition:
- Package seven_segment_scanner_pkg holds:
  - the 16-entry hex-to-segment table;
  - the state encoding (IDLE=2'd0, BLANK=2'd1, DRIVE=2'd2);
  - SEG_OFF=8'h00 and SEG_DP=8'h01.
- One sub-module, scan_slot_timer: slot counter plus BLANK/DRIVE phase and end-of-slot strobe, parameterised by PRESCALE and BLANK_CYCLES.

Test Plan:
Bench configuration: NUM_DIGITS=4, PRESCALE=8, BLANK_CYCLES=2.
1. Assert rst_n=0 at any time -> an=4'b1111, seg=8'h00, load_ready=1, frame_done=0 within the same cycle (async).
2. Idle, load 16'h1234 (dp=0, blank=0), then enable=1:
   - first 2 cycles: an=1111, seg=8'h66;
   - next 6 cycles: an=1110, seg=8'h66;
   - then digit1: seg=8'hF2, an=1101; then 8'hDA; then 8'h60;
   - frame_done high only on cycle 31.
3. Mid-frame, load 16'hABCD -> load_ready=0 the next cycle, display unchanged. After frame_done, digit0 seg=8'h7A and load_ready=1.
4. Load data 16'h0056, dp=4'b0010, blank=4'b1000 -> digit0 seg=8'hBE, digit1 seg=8'hB7, digit2 seg=8'hFC, digit3 seg=8'h00 (anode still pulses).
5. Drop enable during digit2 DRIVE -> next cycle an=1111, seg=00. Re-enable -> restarts at digit0 BLANK with counter 0.
6. Accept a word, then assert rst_n=0 before frame_done -> after release, display=0 (digit0 seg=8'hFC once enabled) and load_ready=1.
